uart_frame_scheduler: RTL

Sequences all traffic onto the scale's single UART byte transmitter. It shares the link between two requesters: periodic weight reports and one-shot event messages such as tare-done or overload. Each message becomes a framed byte sequence handed out over a valid/ready byte handshake. The block sits between the weighing datapath and the UART bit-level serializer, replacing ad-hoc free-running byte sequencing.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_period_timer.sv | 28 ++
 rtl/uart_frame_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame scheduler.
// The checksum byte is built only with UART_FRAME_CHECKSUM_EN defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TYPE,
        S_P0,
        S_P1,
        S_P2,
        S_P3,
        S_CSUM
    } frame_state_t;

    localparam logic [7:0] TYPE_WEIGHT      = 8'h01;
    localparam logic [7:0] TYPE_EVENT       = 8'h02;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    // f = {P3, P2, P1, P0, TYPE}; the header never enters the checksum
    function automatic logic [7:0] frame_csum(input logic [39:0] f);
        return f[7:0] ^ f[15:8] ^ f[23:16] ^ f[31:24] ^ f[39:32];
    endfunction

endpackage

// File: rtl/uart_period_timer.sv
// Free-running 0..PERIOD_TICKS-1 counter with a terminal-count pulse.
// Shared by the frame scheduler and the display refresh logic.
module uart_period_timer #(
    parameter int PERIOD_TICKS = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tc
);

    localparam int CW = (PERIOD_TICKS > 2) ? $clog2(PERIOD_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_TICKS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_scheduler.sv
// Arbitrates weight reports and event messages onto one UART byte stream.
// Define UART_FRAME_CHECKSUM_EN for 7-byte frames with a trailing CSUM byte.
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int         PERIOD_TICKS = 1_000_000,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic [24:0] weight_in,
    input  logic        weight_valid,
    input  logic        evt_req,
    input  logic [7:0]  evt_code,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        evt_overrun
);

    frame_state_t r_state;
    frame_state_t w_next_state;
    logic [7:0]   w_next_byte;

    logic [24:0] r_wt_hold;
    logic        r_fresh;
    logic        r_wt_pend;
    logic [7:0]  r_evt_hold;
    logic        r_evt_pend;
    logic [39:0] r_frame;

    logic        w_tc;
    logic        w_idle;
    logic        w_grant_evt;
    logic        w_grant_wt;
    logic        w_xfer;
    logic [39:0] w_wt_frame;
    logic [39:0] w_evt_frame;

    uart_period_timer #(
        .PERIOD_TICKS(PERIOD_TICKS)
    ) u_timer (
        .i_clk  (clk_100MHz),
        .i_rst_n(rst_n),
        .o_tc   (w_tc)
    );

    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_evt = w_idle & r_evt_pend;
    assign w_grant_wt  = w_idle & ~r_evt_pend & r_wt_pend;
    assign w_xfer      = byte_valid & byte_ready;

    assign w_wt_frame  = {{8{r_wt_hold[24]}}, r_wt_hold[23:0], TYPE_WEIGHT};
    assign w_evt_frame = {24'h0, r_evt_hold, TYPE_EVENT};

    // Old fresh is consumed on the terminal count; a same-cycle sample stays fresh
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wt_hold <= '0;
            r_fresh   <= 1'b0;
            r_wt_pend <= 1'b0;
        end else begin
            if (weight_valid) begin
                r_wt_hold <= weight_in;
            end
            if (weight_valid) begin
                r_fresh <= 1'b1;
            end else if (w_tc && r_fresh && !r_wt_pend) begin
                r_fresh <= 1'b0;
            end
            if (w_tc && r_fresh && !r_wt_pend) begin
                r_wt_pend <= 1'b1;
            end else if (w_grant_wt) begin
                r_wt_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_hold  <= '0;
            r_evt_pend  <= 1'b0;
            evt_overrun <= 1'b0;
        end else if (evt_req) begin
            r_evt_hold <= evt_code;
            r_evt_pend <= 1'b1;
            if (r_evt_pend && !w_grant_evt) begin
                evt_overrun <= 1'b1;
            end
        end else if (w_grant_evt) begin
            r_evt_pend <= 1'b0;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        w_next_byte  = 8'h00;
        unique case (r_state)
            S_HDR: begin
                w_next_state = S_TYPE;
                w_next_byte  = r_frame[7:0];
            end
            S_TYPE: begin
                w_next_state = S_P0;
                w_next_byte  = r_frame[15:8];
            end
            S_P0: begin
                w_next_state = S_P1;
                w_next_byte  = r_frame[23:16];
            end
            S_P1: begin
                w_next_state = S_P2;
                w_next_byte  = r_frame[31:24];
            end
            S_P2: begin
                w_next_state = S_P3;
                w_next_byte  = r_frame[39:32];
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_P3: begin
                w_next_state = S_CSUM;
                w_next_byte  = frame_csum(r_frame);
            end
`endif
            default: begin
                w_next_state = S_IDLE;
                w_next_byte  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (w_idle) begin
            if (w_grant_evt || w_grant_wt) begin
                r_frame    <= w_grant_evt ? w_evt_frame : w_wt_frame;
                r_state    <= S_HDR;
                byte_data  <= HDR_BYTE;
                byte_valid <= 1'b1;
                busy       <= 1'b1;
            end
        end else if (w_xfer) begin
            r_state    <= w_next_state;
            byte_data  <= w_next_byte;
            byte_valid <= (w_next_state != S_IDLE);
            busy       <= (w_next_state != S_IDLE);
        end
    end

endmodule
